// File: rtl/maze_pkg.sv
// Shared types and heading helpers for the maze wall-follower.
package maze_pkg;

  typedef enum logic [2:0] {
    MV_STOP  = 3'd0,
    MV_FWD   = 3'd1,
    MV_LEFT  = 3'd2,
    MV_RIGHT = 3'd3,
    MV_UTURN = 3'd4
  } move_t;

  typedef enum logic [1:0] {
    HDG_N = 2'd0,
    HDG_E = 2'd1,
    HDG_S = 2'd2,
    HDG_W = 2'd3
  } hdg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH,
    S_FAULT
  } state_t;

  function automatic hdg_t turn_left(input hdg_t h);
    return hdg_t'(h + 2'd3);
  endfunction

  function automatic hdg_t turn_right(input hdg_t h);
    return hdg_t'(h + 2'd1);
  endfunction

  function automatic hdg_t turn_back(input hdg_t h);
    return hdg_t'(h + 2'd2);
  endfunction

endpackage

// File: rtl/maze_pose_tracker.sv
// Pose register plus combinational next-pose / out-of-grid computation.
module maze_pose_tracker
  import maze_pkg::*;
#(
  parameter int unsigned ROWS      = 9,
  parameter int unsigned COLS      = 9,
  parameter int unsigned START_R   = 4,
  parameter int unsigned START_C   = 0,
  parameter int unsigned START_HDG = 1,
  parameter int unsigned RW        = 4,
  parameter int unsigned CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  move_t         dec,
  input  logic          upd,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output hdg_t          heading,
  output logic [RW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output hdg_t          nxt_hdg,
  output logic          oob
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  always_comb begin
    case (dec)
      MV_LEFT:  nxt_hdg = turn_left(heading);
      MV_RIGHT: nxt_hdg = turn_right(heading);
      MV_UTURN: nxt_hdg = turn_back(heading);
      default:  nxt_hdg = heading;
    endcase

    // Step along the post-rotation heading; an edge hit leaves the pose as-is.
    nxt_row = row;
    nxt_col = col;
    oob     = 1'b0;
    case (nxt_hdg)
      HDG_N:   if (row == '0)     oob = 1'b1; else nxt_row = row - RW'(1);
      HDG_E:   if (col == COL_MAX) oob = 1'b1; else nxt_col = col + CW'(1);
      HDG_S:   if (row == ROW_MAX) oob = 1'b1; else nxt_row = row + RW'(1);
      default: if (col == '0)     oob = 1'b1; else nxt_col = col - CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row     <= RW'(START_R);
      col     <= CW'(START_C);
      heading <= hdg_t'(START_HDG[1:0]);
    end else if (upd) begin
      row     <= nxt_row;
      col     <= nxt_col;
      heading <= nxt_hdg;
    end
  end

endmodule

// File: rtl/maze_wall_follower.sv
// Wall-following maze explorer: run FSM, hand-rule decision, exit detect.
// Optional dead-end counter enabled by defining MAZE_DEADEND_CNT_EN.
module maze_wall_follower
  import maze_pkg::*;
#(
  parameter int unsigned ROWS      = 9,
  parameter int unsigned COLS      = 9,
  parameter int unsigned START_R   = 4,
  parameter int unsigned START_C   = 0,
  parameter int unsigned START_HDG = 1,
  parameter int unsigned EXIT_R    = 4,
  parameter int unsigned EXIT_C    = 8,
  parameter int unsigned HAND      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sense_vld,
  input  logic                     left,
  input  logic                     mid,
  input  logic                     right,
  output logic [2:0]               move,
  output logic                     move_vld,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [1:0]               heading,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               deadends
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  state_t          state, state_nxt;
  move_t           dec;
  hdg_t            hdg, nxt_hdg;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_col;
  logic            oob, take, commit, hit;

  always_comb begin
    if (HAND == 0) begin
      if (!left)       dec = MV_LEFT;
      else if (!mid)   dec = MV_FWD;
      else if (!right) dec = MV_RIGHT;
      else             dec = MV_UTURN;
    end else begin
      if (!right)      dec = MV_RIGHT;
      else if (!mid)   dec = MV_FWD;
      else if (!left)  dec = MV_LEFT;
      else             dec = MV_UTURN;
    end
  end

  assign take   = (state == S_RUN) && sense_vld;
  assign commit = take && !oob;
  assign hit    = (nxt_row == RW'(EXIT_R)) && (nxt_col == CW'(EXIT_C));

  maze_pose_tracker #(
    .ROWS(ROWS), .COLS(COLS), .START_R(START_R), .START_C(START_C),
    .START_HDG(START_HDG), .RW(RW), .CW(CW)
  ) u_pose (
    .clk(clk), .rst_n(rst_n), .dec(dec), .upd(commit),
    .row(row), .col(col), .heading(hdg),
    .nxt_row(nxt_row), .nxt_col(nxt_col), .nxt_hdg(nxt_hdg), .oob(oob)
  );

  assign heading = hdg;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A decision taken while en falls still completes; fault/exit outrank IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (en) state_nxt = S_RUN;
      S_RUN: begin
        if (take && oob)          state_nxt = S_FAULT;
        else if (commit && hit)   state_nxt = S_FINISH;
        else if (!en)             state_nxt = S_IDLE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      move     <= MV_STOP;
      move_vld <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      move_vld <= take;
      if (take)
        move <= oob ? MV_STOP : dec;
      else if (state == S_FINISH || state == S_FAULT)
        move <= MV_STOP;
      if (take && oob)    err  <= 1'b1;
      if (commit && hit)  done <= 1'b1;
    end
  end

`ifdef MAZE_DEADEND_CNT_EN
  logic [7:0] de_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      de_cnt <= '0;
    else if (take && dec == MV_UTURN && de_cnt != '1)
      de_cnt <= de_cnt + 8'd1;
  end

  assign deadends = de_cnt;
`else
  assign deadends = '0;
`endif

endmodule

// File: tb/tb_maze_wall_follower.sv
// Bench for maze_wall_follower: left- and right-hand instances against a pose model.
module tb_maze_wall_follower;

  localparam int NR = 9, NC = 9, SR = 4, SC = 0, SH = 1, ER = 4, EC = 8;
`ifdef MAZE_DEADEND_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, en, sense_vld, left, mid, right;
  logic [2:0] mv [2];
  logic       vld [2];
  logic [3:0] rw [2];
  logic [3:0] cl [2];
  logic [1:0] hd [2];
  logic       dn [2];
  logic       er [2];
  logic [7:0] dd [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maze_wall_follower #(.HAND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sense_vld(sense_vld),
    .left(left), .mid(mid), .right(right),
    .move(mv[0]), .move_vld(vld[0]), .row(rw[0]), .col(cl[0]), .heading(hd[0]),
    .done(dn[0]), .err(er[0]), .deadends(dd[0])
  );

  maze_wall_follower #(.HAND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sense_vld(sense_vld),
    .left(left), .mid(mid), .right(right),
    .move(mv[1]), .move_vld(vld[1]), .row(rw[1]), .col(cl[1]), .heading(hd[1]),
    .done(dn[1]), .err(er[1]), .deadends(dd[1])
  );

  // Model: mode 0 idle, 1 running, 2 finished, 3 faulted
  typedef struct {
    int mode; int r; int c; int h; int mv; bit vld; bit dn; bit er; int de;
  } mdl_t;

  mdl_t md [2];

  function automatic mdl_t mreset();
    mdl_t n;
    n.mode = 0; n.r = SR; n.c = SC; n.h = SH; n.mv = 0;
    n.vld = 0; n.dn = 0; n.er = 0; n.de = 0;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit rst, bit e, bit sv,
                                 bit l, bit m, bit r, int hand);
    mdl_t n = s;
    int dr [4] = '{-1, 0, 1, 0};
    int dc [4] = '{0, 1, 0, -1};
    bit open [3];
    int mvs  [3];
    int d, rot, nh, nr, nc;
    if (!rst) return mreset();
    n.vld = 0;
    if (s.mode == 0) begin
      if (e) n.mode = 1;
    end else if (s.mode == 1) begin
      if (sv) begin
        if (hand == 0) begin
          open = '{!l, !m, !r}; mvs = '{2, 1, 3};
        end else begin
          open = '{!r, !m, !l}; mvs = '{3, 1, 2};
        end
        d = 4;
        for (int i = 2; i >= 0; i--) if (open[i]) d = mvs[i];
        rot = (d == 1) ? 0 : (d == 2) ? 3 : (d == 3) ? 1 : 2;
        nh = (s.h + rot) % 4;
        nr = s.r + dr[nh];
        nc = s.c + dc[nh];
        if (d == 4 && CNT_ON && s.de < 255) n.de = s.de + 1;
        n.vld = 1;
        if (nr < 0 || nr >= NR || nc < 0 || nc >= NC) begin
          n.mv = 0; n.er = 1; n.mode = 3;
        end else begin
          n.r = nr; n.c = nc; n.h = nh; n.mv = d;
          if (nr == ER && nc == EC) begin
            n.dn = 1; n.mode = 2;
          end else if (!e) n.mode = 0;
        end
      end else if (!e) n.mode = 0;
    end else begin
      n.mv = 0;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("move_h%0d", k),     int'(mv[k]),  md[k].mv);
      chk($sformatf("move_vld_h%0d", k), int'(vld[k]), int'(md[k].vld));
      chk($sformatf("row_h%0d", k),      int'(rw[k]),  md[k].r);
      chk($sformatf("col_h%0d", k),      int'(cl[k]),  md[k].c);
      chk($sformatf("heading_h%0d", k),  int'(hd[k]),  md[k].h);
      chk($sformatf("done_h%0d", k),     int'(dn[k]),  int'(md[k].dn));
      chk($sformatf("err_h%0d", k),      int'(er[k]),  int'(md[k].er));
      chk($sformatf("deadends_h%0d", k), int'(dd[k]),  md[k].de);
    end
  endtask

  task automatic run(input bit rst, input bit e, input bit sv,
                     input bit l, input bit m, input bit r);
    rst_n = rst; en = e; sense_vld = sv; left = l; mid = m; right = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) md[k] = mstep(md[k], rst, e, sv, l, m, r, k);
    #1;
    check_all();
  endtask

  typedef struct {
    bit rst; bit e; bit sv; bit l; bit m; bit r;
    int emv; bit evld; int er_; int ec; int eh; bit edn; bit eer;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_n = 1'b0; en = 1'b0; sense_vld = 1'b0; left = 1'b1; mid = 1'b1; right = 1'b1;
    md[0] = mreset(); md[1] = mreset();

    // Left-hand walk: {rst,en,sv,l,m,r, move,vld,row,col,hdg,done,err}
    tbl[0]  = '{0,0,0,1,1,1, 0,0,4,0,1,0,0};
    tbl[1]  = '{1,1,0,1,1,1, 0,0,4,0,1,0,0};
    tbl[2]  = '{1,1,1,1,0,1, 1,1,4,1,1,0,0};
    tbl[3]  = '{1,1,1,0,0,0, 2,1,3,1,0,0,0};
    tbl[4]  = '{1,1,0,0,0,0, 2,0,3,1,0,0,0};
    tbl[5]  = '{1,1,1,1,1,0, 3,1,3,2,1,0,0};
    tbl[6]  = '{1,1,1,1,1,1, 4,1,3,1,3,0,0};
    tbl[7]  = '{1,0,1,1,0,1, 1,1,3,0,3,0,0};
    tbl[8]  = '{1,0,1,1,0,1, 1,0,3,0,3,0,0};
    tbl[9]  = '{1,1,1,1,0,1, 1,0,3,0,3,0,0};
    tbl[10] = '{1,1,1,1,0,1, 0,1,3,0,3,0,1};
    tbl[11] = '{1,1,1,1,0,1, 0,0,3,0,3,0,1};
    tbl[12] = '{0,1,1,1,0,1, 0,0,4,0,1,0,0};

    for (int i = 0; i < 13; i++) begin
      run(tbl[i].rst, tbl[i].e, tbl[i].sv, tbl[i].l, tbl[i].m, tbl[i].r);
      chk($sformatf("tbl%0d_move", i), int'(mv[0]), tbl[i].emv);
      chk($sformatf("tbl%0d_vld", i),  int'(vld[0]), int'(tbl[i].evld));
      chk($sformatf("tbl%0d_row", i),  int'(rw[0]), tbl[i].er_);
      chk($sformatf("tbl%0d_col", i),  int'(cl[0]), tbl[i].ec);
      chk($sformatf("tbl%0d_hdg", i),  int'(hd[0]), tbl[i].eh);
      chk($sformatf("tbl%0d_done", i), int'(dn[0]), int'(tbl[i].edn));
      chk($sformatf("tbl%0d_err", i),  int'(er[0]), int'(tbl[i].eer));
    end

    // Straight run to the exit, then further strobes are ignored
    run(0, 0, 0, 1, 1, 1);
    run(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) run(1, 1, 1, 1, 0, 1);
    chk("exit_done", int'(dn[0]), 1);
    chk("exit_col",  int'(cl[0]), 8);
    chk("exit_move", int'(mv[0]), 1);
    run(1, 1, 1, 1, 0, 1);
    chk("finish_vld",  int'(vld[0]), 0);
    chk("finish_move", int'(mv[0]), 0);
    run(1, 1, 1, 1, 0, 1);
    chk("finish_move_hold", int'(mv[0]), 0);

    // North-edge fault from (0,3)
    run(0, 0, 0, 1, 1, 1);
    run(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) run(1, 1, 1, 1, 0, 1);
    run(1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) run(1, 1, 1, 1, 0, 1);
    chk("edge_row", int'(rw[0]), 0);
    chk("edge_col", int'(cl[0]), 3);
    run(1, 1, 1, 1, 0, 1);
    chk("fault_err",  int'(er[0]), 1);
    chk("fault_move", int'(mv[0]), 0);
    chk("fault_row",  int'(rw[0]), 0);
    run(1, 1, 1, 1, 0, 1);
    chk("fault_vld", int'(vld[0]), 0);

    // Mid-run reset at (2,5), then right-hand choice
    run(0, 0, 0, 1, 1, 1);
    run(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) run(1, 1, 1, 1, 0, 1);
    run(1, 1, 1, 0, 1, 1);
    run(1, 1, 1, 1, 0, 1);
    chk("mid_row", int'(rw[0]), 2);
    chk("mid_col", int'(cl[0]), 5);
    run(0, 1, 1, 1, 0, 1);
    chk("rst_row", int'(rw[0]), 4);
    chk("rst_col", int'(cl[0]), 0);
    chk("rst_hdg", int'(hd[0]), 1);
    run(1, 1, 0, 1, 1, 1);
    run(1, 1, 1, 0, 1, 0);
    chk("hand1_move", int'(mv[1]), 3);
    chk("hand0_move", int'(mv[0]), 2);

    // Dead-end saturation: ping-pong between (4,0) and (4,1)
    run(0, 0, 0, 1, 1, 1);
    run(1, 1, 0, 1, 1, 1);
    run(1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 300; i++) run(1, 1, 1, 1, 1, 1);
    chk("deadend_sat_h0", int'(dd[0]), CNT_ON ? 255 : 0);
    chk("deadend_sat_h1", int'(dd[1]), CNT_ON ? 255 : 0);

    // Random walls, strobes, enables and occasional resets
    for (int i = 0; i < 3000; i++)
      run($urandom_range(0, 59) != 0, $urandom_range(0, 9) != 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
